// File: rtl/pattern_det_pkg.sv
// Shared types and defaults for the serial pattern detector.
package pattern_det_pkg;

    localparam int DEF_MAX_LEN       = 8;
    localparam int DEF_COUNT_WIDTH   = 16;
    localparam int DEF_RESET_PATTERN = 1;    // "01" when paired with DEF_RESET_LEN
    localparam int DEF_RESET_LEN     = 2;
    localparam int DEF_RESET_OVERLAP = 1;

    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    typedef enum logic {
        FILLING = 1'b0,
        ARMED   = 1'b1
    } fill_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; a clear and an increment on the same cycle yield 1.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] base;

    assign base = clear ? '0 : count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear || inc)
            count <= (inc && !(&base)) ? base + WIDTH'(1) : base;
    end

endmodule

// File: rtl/serial_pattern_detector.sv
// Detects a programmable 1..MAX_LEN bit pattern on a qualified serial stream,
// with overlap/non-overlap modes and a saturating match counter.
module serial_pattern_detector
    import pattern_det_pkg::*;
#(
    parameter int                 MAX_LEN       = DEF_MAX_LEN,
    parameter int                 COUNT_WIDTH   = DEF_COUNT_WIDTH,
    parameter logic [MAX_LEN-1:0] RESET_PATTERN = MAX_LEN'(DEF_RESET_PATTERN),
    parameter int                 RESET_LEN     = DEF_RESET_LEN,
    parameter bit                 RESET_OVERLAP = 1'(DEF_RESET_OVERLAP),
    localparam int                LEN_W         = len_w(MAX_LEN)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic                   input_sequence,
    input  logic                   cfg_load,
    input  logic [MAX_LEN-1:0]     cfg_pattern,
    input  logic [LEN_W-1:0]       cfg_len,
    input  logic                   cfg_overlap,
    input  logic                   count_clear,
    output logic                   condition_met,
    output logic [COUNT_WIDTH-1:0] match_count,
    output logic                   cfg_error
);

    // Only MAX_LEN-1 past bits are stored: the incoming bit completes the
    // MAX_LEN-bit history window, and the oldest bit is never needed again.
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [MAX_LEN-1:0] hist_win, mask;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d, fill_q, fill_d, fill_inc;
    logic               ovl_q, ovl_d, err_d, match, cfg_ok;
    fill_state_e        state_q, state_d;

    assign cfg_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q        <= '0;
            fill_q        <= '0;
            state_q       <= FILLING;
            pat_q         <= RESET_PATTERN;
            len_q         <= LEN_W'(RESET_LEN);
            ovl_q         <= RESET_OVERLAP;
            condition_met <= 1'b0;
            cfg_error     <= 1'b0;
        end else begin
            hist_q        <= hist_d;
            fill_q        <= fill_d;
            state_q       <= state_d;
            pat_q         <= pat_d;
            len_q         <= len_d;
            ovl_q         <= ovl_d;
            condition_met <= match;
            cfg_error     <= err_d;
        end
    end

    always_comb begin
        hist_d   = hist_q;
        fill_d   = fill_q;
        state_d  = state_q;
        pat_d    = pat_q;
        len_d    = len_q;
        ovl_d    = ovl_q;
        err_d    = 1'b0;
        match    = 1'b0;
        hist_win = {hist_q, input_sequence};
        mask     = '0;
        for (int i = 0; i < MAX_LEN; i++)
            mask[i] = (i < int'(len_q));
        fill_inc = (state_q == ARMED) ? len_q : fill_q + LEN_W'(1);

        // A load owns the cycle: any data bit alongside it is dropped.
        if (cfg_load) begin
            if (cfg_ok) begin
                pat_d   = cfg_pattern;
                len_d   = cfg_len;
                ovl_d   = cfg_overlap;
                hist_d  = '0;
                fill_d  = '0;
                state_d = FILLING;
            end else begin
                err_d = 1'b1;
            end
        end else if (in_valid) begin
            hist_d = hist_win[MAX_LEN-2:0];
            match  = (fill_inc == len_q) && (((hist_win ^ pat_q) & mask) == '0);
            if (match && !ovl_q) begin
                fill_d  = '0;
                state_d = FILLING;
            end else begin
                fill_d  = fill_inc;
                state_d = (fill_inc == len_q) ? ARMED : FILLING;
            end
        end
    end

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_count (
        .clk   (clk),
        .reset (reset),
        .clear (count_clear),
        .inc   (match),
        .count (match_count)
    );

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Directed plus random checks of serial_pattern_detector against a queue-based model.
module tb_serial_pattern_detector;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               in_valid = 1'b0, input_sequence = 1'b0;
    logic               cfg_load = 1'b0, cfg_overlap = 1'b0, count_clear = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               cond_a, err_a, cond_b, err_b;
    logic [15:0]        cnt_a;
    logic [1:0]         cnt_b;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit                 hist[$];
    logic [MAX_LEN-1:0] m_pat;
    int                 m_len, m_cnt, m_cnt2;
    bit                 m_ovl;

    always #5 clk = ~clk;

    serial_pattern_detector #(.MAX_LEN(MAX_LEN), .COUNT_WIDTH(16)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .input_sequence(input_sequence),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .count_clear(count_clear),
        .condition_met(cond_a), .match_count(cnt_a), .cfg_error(err_a));

    serial_pattern_detector #(.MAX_LEN(MAX_LEN), .COUNT_WIDTH(2)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .input_sequence(input_sequence),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .count_clear(count_clear),
        .condition_met(cond_b), .match_count(cnt_b), .cfg_error(err_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_pat  = MAX_LEN'(1);
        m_len  = 2;
        m_ovl  = 1'b1;
        m_cnt  = 0;
        m_cnt2 = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; cfg_load = 1'b0; count_clear = 1'b0;
        #1;
        model_reset();
        chk("rst_cond", 32'(cond_a), 0);
        chk("rst_cnt",  32'(cnt_a),  0);
        chk("rst_err",  32'(err_a),  0);
        chk("rst_cnt2", 32'(cnt_b),  0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One clock: drive, predict, then sample 1 time unit after the edge.
    task automatic step(input bit v, input bit b, input bit ld, input logic [7:0] p,
                        input int l, input bit ov, input bit clr);
        bit hit, exp_err;
        @(negedge clk);
        in_valid = v; input_sequence = b; cfg_load = ld; cfg_pattern = p;
        cfg_len = LEN_W'(l); cfg_overlap = ov; count_clear = clr;
        hit = 1'b0; exp_err = 1'b0;
        if (ld) begin
            if (l >= 1 && l <= MAX_LEN) begin
                m_pat = p; m_len = l; m_ovl = ov; hist.delete();
            end else begin
                exp_err = 1'b1;
            end
        end else if (v) begin
            hist.push_back(b);
            if (hist.size() > MAX_LEN) void'(hist.pop_front());
            if (hist.size() >= m_len) begin
                hit = 1'b1;
                for (int i = 0; i < m_len; i++)
                    if (hist[hist.size() - 1 - i] != m_pat[i]) hit = 1'b0;
            end
            if (hit && !m_ovl) hist.delete();
        end
        if (clr) begin m_cnt = 0; m_cnt2 = 0; end
        if (hit) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        @(posedge clk);
        #1;
        chk("cond", 32'(cond_a), 32'(hit));
        chk("count", 32'(cnt_a), 32'(m_cnt));
        chk("cfg_err", 32'(err_a), 32'(exp_err));
        chk("count_sat2", 32'(cnt_b), 32'(m_cnt2));
    endtask

    task automatic bit_in(input bit b);
        step(1'b1, b, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    endtask

    initial begin
        bit dflt[9] = '{0, 0, 1, 0, 1, 1, 0, 0, 1};
        model_reset();
        reset = 1'b1;
        #12;
        reset = 1'b0;
        do_reset();

        // defaults "01", overlap
        foreach (dflt[i]) bit_in(dflt[i]);
        chk("dflt_total", 32'(cnt_a), 3);
        chk("dflt_sat2", 32'(cnt_b), 3);

        // "11" overlapping, then non-overlapping
        step(1'b0, 1'b0, 1'b1, 8'b11, 2, 1'b1, 1'b1);
        repeat (4) bit_in(1'b1);
        chk("ovl11_total", 32'(cnt_a), 3);
        step(1'b0, 1'b0, 1'b1, 8'b11, 2, 1'b0, 1'b1);
        repeat (4) bit_in(1'b1);
        chk("novl11_total", 32'(cnt_a), 2);

        // "000" straight after reset
        do_reset();
        step(1'b0, 1'b0, 1'b1, 8'b000, 3, 1'b1, 1'b0);
        bit_in(1'b0); bit_in(1'b0);
        chk("p000_early", 32'(cnt_a), 0);
        bit_in(1'b0);
        chk("p000_total", 32'(cnt_a), 1);

        // rejected loads leave "01" detection intact
        do_reset();
        bit_in(1'b0);
        step(1'b0, 1'b0, 1'b1, 8'hff, 0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'hff, MAX_LEN + 1, 1'b0, 1'b0);
        bit_in(1'b1);
        chk("bad_load_kept", 32'(cnt_a), 1);

        // load wins over a completing bit; clear on a match cycle
        bit_in(1'b0);
        step(1'b1, 1'b1, 1'b1, 8'b01, 2, 1'b1, 1'b0);
        bit_in(1'b1);
        chk("load_discard", 32'(cnt_a), 1);
        bit_in(1'b0);
        step(1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1);
        chk("clear_then_count", 32'(cnt_a), 1);

        // saturation of the 2-bit counter
        repeat (5) begin bit_in(1'b0); bit_in(1'b1); end
        chk("sat2_final", 32'(cnt_b), 3);

        // reset mid-pattern discards history
        bit_in(1'b0);
        do_reset();
        bit_in(1'b1);
        chk("mid_rst_cond", 32'(cond_a), 0);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            int r = $urandom_range(0, 99);
            bit clr = ($urandom_range(0, 29) == 0);
            if (r < 5)
                step(1'b0, 1'b0, 1'b1, 8'($urandom), $urandom_range(1, (r < 2) ? MAX_LEN : 3),
                     1'($urandom), clr);
            else if (r < 7)
                step(1'b0, 1'b0, 1'b1, 8'($urandom), (r == 5) ? 0 : $urandom_range(MAX_LEN + 1, 15),
                     1'($urandom), clr);
            else
                step($urandom_range(0, 3) != 0, 1'($urandom), 1'b0, 8'h00, 0, 1'b0, clr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
